// File: rtl/pulse_frame_decoder.sv
// Pulse-width-coded frame decoder: sync preamble, DATA_W metadata bits sliced by
// high/low phase length, then a scan phase that flips coil current polarity per edge.
module pulse_frame_decoder #(
  parameter int SYNC_EDGES = 3,
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 10,
  parameter int TIMEOUT    = 1000,
  parameter int SCAN_LEN   = 0
) (
  input  logic              CLK_IN,
  input  logic              rst,
  input  logic              DATA_IN,
  output logic [DATA_W-1:0] amplitude,
  output logic              pos_current,
  output logic              frame_valid,
  output logic              err,
  output logic              done,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SYNC      = 4'd1,
    ARM       = 4'd2,
    HIGH_PH   = 4'd3,
    LOW_PH    = 4'd4,
    BIT_GAP   = 4'd5,
    SCAN_WAIT = 4'd6,
    SCAN_POS  = 4'd7,
    SCAN_NEG  = 4'd8
  } state_t;

  localparam int EW = (SYNC_EDGES > 2) ? $clog2(SYNC_EDGES) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int HW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam logic signed [CNT_W:0] ACC_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic signed [CNT_W:0] ACC_ONE = 1;

  // One-step saturating move of the phase accumulator; never wraps.
  function automatic logic signed [CNT_W:0] sat_step(input logic signed [CNT_W:0] a,
                                                    input logic up);
    if (up) return (a == ACC_MAX) ? a : a + ACC_ONE;
    else    return (a == -ACC_MAX) ? a : a - ACC_ONE;
  endfunction

  state_t                  state_q, state_d;
  logic                    sync_p0, sync_p1, hist_p2;
  logic                    edge_det;
  logic [EW-1:0]           edge_cnt;
  logic [IW-1:0]           bit_idx;
  logic [HW-1:0]           half_cnt;
  logic [CNT_W-1:0]        tmo_cnt;
  logic signed [CNT_W:0]   acc;
  logic signed [CNT_W:0]   acc_dec;
  logic [DATA_W-1:0]       shreg;
  logic                    tmo_hit;
  logic                    scan_last;
  logic                    in_scan;

  // Stage p0/p1: metastability synchroniser; p2: history for edge detection.
  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      sync_p0 <= DATA_IN;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign edge_det  = sync_p1 ^ hist_p2;
  assign tmo_hit   = (state_q != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT));
  assign in_scan   = (state_q == SCAN_POS) || (state_q == SCAN_NEG);
  assign scan_last = (SCAN_LEN != 0) && (half_cnt == HW'(SCAN_LEN - 1));
  assign acc_dec   = sat_step(acc, 1'b0);

  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (edge_det) state_d = SYNC;
      SYNC:      if (edge_det && edge_cnt == EW'(SYNC_EDGES - 1)) state_d = ARM;
      ARM:       if (edge_det) state_d = HIGH_PH;
      HIGH_PH:   if (edge_det) state_d = LOW_PH;
      LOW_PH:    if (edge_det) state_d = (bit_idx == '0) ? SCAN_WAIT : BIT_GAP;
      BIT_GAP:   if (edge_det) state_d = HIGH_PH;
      SCAN_WAIT: if (edge_det) state_d = SCAN_POS;
      SCAN_POS:  if (edge_det) state_d = scan_last ? IDLE : SCAN_NEG;
      SCAN_NEG:  if (edge_det) state_d = scan_last ? IDLE : SCAN_POS;
      default:   state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  always_comb begin
    state       = state_q;
    frame_valid = in_scan;
    pos_current = (state_q != SCAN_NEG);
  end

  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) begin
      amplitude <= '0;
      shreg     <= '0;
      acc       <= '0;
      edge_cnt  <= '0;
      bit_idx   <= '0;
      half_cnt  <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      err  <= tmo_hit;
      done <= !tmo_hit && edge_det && scan_last && in_scan;
      if (state_q == IDLE || edge_det || tmo_hit) tmo_cnt <= '0;
      else if (tmo_cnt != CNT_W'(TIMEOUT))        tmo_cnt <= tmo_cnt + 1'b1;

      // Timeout takes priority over any edge seen in the same cycle.
      if (tmo_hit) begin
        amplitude <= '0;
        shreg     <= '0;
        acc       <= '0;
        edge_cnt  <= '0;
        half_cnt  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            half_cnt <= '0;
            if (edge_det) edge_cnt <= EW'(1);
          end
          SYNC:    if (edge_det) edge_cnt <= edge_cnt + 1'b1;
          ARM: if (edge_det) begin
            acc     <= '0;
            bit_idx <= IW'(DATA_W - 1);
          end
          HIGH_PH: acc <= sat_step(acc, 1'b1);
          LOW_PH: begin
            acc <= acc_dec;
            if (edge_det) shreg[bit_idx] <= !acc_dec[CNT_W] && (acc_dec != '0);
          end
          BIT_GAP: if (edge_det) begin
            acc     <= '0;
            bit_idx <= bit_idx - 1'b1;
          end
          SCAN_WAIT: if (edge_det) begin
            amplitude <= shreg;
            half_cnt  <= '0;
          end
          SCAN_POS, SCAN_NEG: if (edge_det && SCAN_LEN != 0) begin
            if (scan_last) begin
              half_cnt  <= '0;
              amplitude <= '0;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_frame_decoder.sv
// Scoreboard bench for pulse_frame_decoder: a default instance and one with
// a 13-bit accumulator, long timeout and a 4-half-cycle bounded scan.
module tb_pulse_frame_decoder;

  localparam int K_SCAN = 0;
  localparam int K_ERR  = 1;
  localparam int K_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, data_a, data_b;
  logic [3:0] a_amp, a_st, b_amp, b_st;
  logic       a_pos, a_fv, a_err, a_done;
  logic       b_pos, b_fv, b_err, b_done;

  pulse_frame_decoder dut_a (
    .CLK_IN(clk), .rst(rst), .DATA_IN(data_a), .amplitude(a_amp), .pos_current(a_pos),
    .frame_valid(a_fv), .err(a_err), .done(a_done), .state(a_st)
  );

  pulse_frame_decoder #(.CNT_W(13), .TIMEOUT(8000), .SCAN_LEN(4)) dut_b (
    .CLK_IN(clk), .rst(rst), .DATA_IN(data_b), .amplitude(b_amp), .pos_current(b_pos),
    .frame_valid(b_fv), .err(b_err), .done(b_done), .state(b_st)
  );

  typedef struct {
    int         dut;
    int         kind;
    logic [3:0] amp;
    logic       pos;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int kind, input logic [3:0] amp, input logic pos);
    ev_t x;
    x.dut = d; x.kind = kind; x.amp = amp; x.pos = pos;
    exp_q.push_back(x);
  endtask

  // Monitor: classify whatever the DUT presents and compare against the queue head.
  task automatic observe(input int d, input logic fv, input logic fvp, input logic pos,
                         input logic posp, input logic e, input logic dn,
                         input logic [3:0] amp, input logic [3:0] st);
    int  kind;
    ev_t x;
    kind = -1;
    if (e)       kind = K_ERR;
    else if (dn) kind = K_DONE;
    else if (fv && (!fvp || pos != posp)) kind = K_SCAN;
    if (kind < 0) return;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got kind %0d, expected none", d, kind);
      return;
    end
    x = exp_q.pop_front();
    check("event_dut", d, x.dut);
    check("event_kind", kind, x.kind);
    check("amplitude", amp, x.amp);
    check("pos_current", pos, x.pos);
    if (kind != K_SCAN) begin
      check("state_idle_on_pulse", st, 0);
      check("frame_valid_on_pulse", fv, 0);
    end
  endtask

  logic a_fv_d = 1'b0, a_pos_d = 1'b1, b_fv_d = 1'b0, b_pos_d = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      observe(0, a_fv, a_fv_d, a_pos, a_pos_d, a_err, a_done, a_amp, a_st);
      observe(1, b_fv, b_fv_d, b_pos, b_pos_d, b_err, b_done, b_amp, b_st);
    end
    a_fv_d  <= a_fv;
    a_pos_d <= a_pos;
    b_fv_d  <= b_fv;
    b_pos_d <= b_pos;
  end

  task automatic tog(input int d, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    if (d == 0) data_a = ~data_a;
    else        data_b = ~data_b;
  endtask

  task automatic preamble(input int d);
    for (int i = 0; i < 3; i++) tog(d, 20);
  endtask

  task automatic send_bit(input int d, input int hi, input int lo);
    tog(d, 20);
    tog(d, hi);
    tog(d, lo);
  endtask

  task automatic send_std(input int d, input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      if (bits[i]) send_bit(d, 30, 10);
      else         send_bit(d, 10, 30);
    end
    push(d, K_SCAN, bits, 1'b1);
    tog(d, 20);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; data_a = 1'b0; data_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_a_state", a_st, 0);
    check("rst_a_amplitude", a_amp, 0);
    check("rst_a_pos_current", a_pos, 1);
    check("rst_a_frame_valid", a_fv, 0);
    check("rst_a_err", a_err, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_state", b_st, 0);
    check("rst_b_frame_valid", b_fv, 0);

    // Frame 1011, six scan toggles, then the line stalls in scan.
    preamble(0);
    send_std(0, 4'b1011);
    drain("frame_1011_entry", 50);
    for (int i = 0; i < 6; i++) begin
      push(0, K_SCAN, 4'b1011, (i % 2) == 1);
      tog(0, 20);
    end
    drain("scan_toggles", 50);
    push(0, K_ERR, 4'b0000, 1'b1);
    drain("timeout_in_scan", 1100);

    // Stall during the first high phase.
    preamble(0);
    tog(0, 20);
    push(0, K_ERR, 4'b0000, 1'b1);
    drain("timeout_in_high_ph", 1100);

    // Recovery frame decodes normally.
    preamble(0);
    send_std(0, 4'b0110);
    drain("frame_0110_entry", 50);
    push(0, K_ERR, 4'b0000, 1'b1);
    drain("timeout_after_0110", 1100);

    // Async reset while in LOW_PH, between clock edges.
    preamble(0);
    tog(0, 20);
    tog(0, 30);
    repeat (5) @(posedge clk);
    #1 check("pre_rst_low_ph", a_st, 4);
    #2 rst = 1'b1; data_a = 1'b0;
    #1;
    check("async_rst_state", a_st, 0);
    check("async_rst_amplitude", a_amp, 0);
    check("async_rst_pos_current", a_pos, 1);
    check("async_rst_frame_valid", a_fv, 0);
    check("async_rst_err", a_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    preamble(0);
    send_std(0, 4'b1111);
    drain("frame_1111_after_rst", 50);
    push(0, K_ERR, 4'b0000, 1'b1);
    drain("timeout_after_1111", 1100);

    // Instance B: long phase, tie, normal 1 and 0, then bounded scan of 4.
    preamble(1);
    send_bit(1, 5000, 1);
    send_bit(1, 25, 25);
    send_bit(1, 30, 10);
    send_bit(1, 10, 30);
    push(1, K_SCAN, 4'b1010, 1'b1);
    tog(1, 20);
    drain("b_frame_1010_entry", 50);
    push(1, K_SCAN, 4'b1010, 1'b0);
    push(1, K_SCAN, 4'b1010, 1'b1);
    push(1, K_SCAN, 4'b1010, 1'b0);
    push(1, K_DONE, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) tog(1, 20);
    drain("b_bounded_scan", 100);
    repeat (5) @(posedge clk);
    #1 check("b_idle_after_done", b_st, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
